// File: rtl/nway_wb_cache.sv
// N-way set-associative write-back / write-allocate data cache, one word per
// line, true-LRU replacement, valid/ready on CPU and memory sides, saturating
// hit/miss statistics.
module nway_wb_cache #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int WAYS       = 4,
  parameter int SETS       = 8,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req_valid,
  output logic                  cpu_req_ready,
  input  logic                  cpu_req_we,
  input  logic [ADDR_WIDTH-1:0] cpu_req_addr,
  input  logic [DATA_WIDTH-1:0] cpu_req_wdata,
  output logic                  cpu_rsp_valid,
  output logic [DATA_WIDTH-1:0] cpu_rsp_rdata,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_req_we,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  output logic [DATA_WIDTH-1:0] mem_req_wdata,
  input  logic                  mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rsp_rdata,
  output logic [CNT_WIDTH-1:0]  hit_count,
  output logic [CNT_WIDTH-1:0]  miss_count
);
  localparam int SET_WIDTH = $clog2(SETS);
  localparam int TAG_WIDTH = ADDR_WIDTH - SET_WIDTH - 2;
  localparam int AGE_WIDTH = $clog2(WAYS);

  typedef enum logic [2:0] {IDLE, WRITEBACK, REFILL_REQ, REFILL_WAIT, RESPOND} state_t;
  state_t state_q;

  // Line storage; age 0 = most recently used, WAYS-1 = least recently used
  logic                  valid_q [SETS][WAYS];
  logic                  dirty_q [SETS][WAYS];
  logic [TAG_WIDTH-1:0]  tag_q   [SETS][WAYS];
  logic [DATA_WIDTH-1:0] data_q  [SETS][WAYS];
  logic [AGE_WIDTH-1:0]  age_q   [SETS][WAYS];

  // Miss context held while the memory side is serviced
  logic                  lat_we_q;
  logic [SET_WIDTH-1:0]  lat_set_q;
  logic [TAG_WIDTH-1:0]  lat_tag_q;
  logic [DATA_WIDTH-1:0] lat_wdata_q;
  logic [AGE_WIDTH-1:0]  lat_way_q;

  logic [SET_WIDTH-1:0] req_set;
  logic [TAG_WIDTH-1:0] req_tag;
  logic [WAYS-1:0]      hit_vec, inv_vec, old_vec;
  logic [AGE_WIDTH-1:0] hit_way, victim_way;
  logic                 hit, accept, victim_dirty;
  logic                 unused_addr_lsbs;

  assign req_set          = cpu_req_addr[SET_WIDTH+1:2];
  assign req_tag          = cpu_req_addr[ADDR_WIDTH-1:SET_WIDTH+2];
  assign unused_addr_lsbs = ^cpu_req_addr[1:0];
  assign cpu_req_ready    = (state_q == IDLE) && !rst;
  assign accept           = cpu_req_valid && cpu_req_ready;
  assign hit              = |hit_vec;

  genvar gi;
  generate
    for (gi = 0; gi < WAYS; gi++) begin : g_way
      assign hit_vec[gi] = valid_q[req_set][gi] && (tag_q[req_set][gi] == req_tag);
      assign inv_vec[gi] = !valid_q[req_set][gi];
      assign old_vec[gi] = (age_q[req_set][gi] == AGE_WIDTH'(WAYS - 1));
    end
  endgenerate

  // Hit way and victim selection (lowest invalid way wins over the LRU way)
  always_comb begin
    hit_way    = '0;
    victim_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (hit_vec[w]) hit_way = AGE_WIDTH'(w);
      if (old_vec[w]) victim_way = AGE_WIDTH'(w);
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (inv_vec[w]) victim_way = AGE_WIDTH'(w);
    end
    victim_dirty = valid_q[req_set][victim_way] && dirty_q[req_set][victim_way];
  end

  // Line write / LRU touch controls: a store hit in IDLE or a refill install
  logic                  wr_en, touch_en, wr_dirty;
  logic [SET_WIDTH-1:0]  wr_set;
  logic [AGE_WIDTH-1:0]  wr_way;
  logic [TAG_WIDTH-1:0]  wr_tag;
  logic [DATA_WIDTH-1:0] wr_data;

  // Select which line is written and whose age is refreshed this cycle
  always_comb begin
    wr_en    = 1'b0;
    touch_en = 1'b0;
    wr_set   = req_set;
    wr_way   = hit_way;
    wr_tag   = req_tag;
    wr_data  = cpu_req_wdata;
    wr_dirty = 1'b1;
    if (state_q == IDLE && accept && hit) begin
      touch_en = 1'b1;
      wr_en    = cpu_req_we;
    end else if (state_q == REFILL_WAIT && mem_rsp_valid) begin
      touch_en = 1'b1;
      wr_en    = 1'b1;
      wr_set   = lat_set_q;
      wr_way   = lat_way_q;
      wr_tag   = lat_tag_q;
      wr_data  = lat_we_q ? lat_wdata_q : mem_rsp_rdata;
      wr_dirty = lat_we_q;
    end
  end

  // Line state and LRU ages; ages stay a permutation of 0..WAYS-1 per set
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          valid_q[s][w] <= 1'b0;
          dirty_q[s][w] <= 1'b0;
          age_q[s][w]   <= AGE_WIDTH'(w);
        end
      end
    end else begin
      if (wr_en) begin
        valid_q[wr_set][wr_way] <= 1'b1;
        dirty_q[wr_set][wr_way] <= wr_dirty;
        tag_q[wr_set][wr_way]   <= wr_tag;
        data_q[wr_set][wr_way]  <= wr_data;
      end
      if (touch_en) begin
        for (int w = 0; w < WAYS; w++) begin
          if (age_q[wr_set][w] < age_q[wr_set][wr_way])
            age_q[wr_set][w] <= age_q[wr_set][w] + AGE_WIDTH'(1);
        end
        age_q[wr_set][wr_way] <= '0;
      end
    end
  end

  // Control FSM with registered CPU response and memory request outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cpu_rsp_valid <= 1'b0;
      cpu_rsp_rdata <= '0;
      mem_req_valid <= 1'b0;
      mem_req_we    <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_wdata <= '0;
      lat_we_q      <= 1'b0;
      lat_set_q     <= '0;
      lat_tag_q     <= '0;
      lat_wdata_q   <= '0;
      lat_way_q     <= '0;
    end else begin
      cpu_rsp_valid <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (hit) begin
              cpu_rsp_valid <= 1'b1;
              cpu_rsp_rdata <= cpu_req_we ? cpu_req_wdata : data_q[req_set][hit_way];
            end else begin
              lat_we_q      <= cpu_req_we;
              lat_set_q     <= req_set;
              lat_tag_q     <= req_tag;
              lat_wdata_q   <= cpu_req_wdata;
              lat_way_q     <= victim_way;
              mem_req_valid <= 1'b1;
              if (victim_dirty) begin
                state_q       <= WRITEBACK;
                mem_req_we    <= 1'b1;
                mem_req_addr  <= {tag_q[req_set][victim_way], req_set, 2'b00};
                mem_req_wdata <= data_q[req_set][victim_way];
              end else begin
                state_q      <= REFILL_REQ;
                mem_req_we   <= 1'b0;
                mem_req_addr <= {req_tag, req_set, 2'b00};
              end
            end
          end
        end
        WRITEBACK: begin
          if (mem_req_ready) begin
            state_q      <= REFILL_REQ;
            mem_req_we   <= 1'b0;
            mem_req_addr <= {lat_tag_q, lat_set_q, 2'b00};
          end
        end
        REFILL_REQ: begin
          if (mem_req_ready) begin
            state_q       <= REFILL_WAIT;
            mem_req_valid <= 1'b0;
          end
        end
        REFILL_WAIT: begin
          if (mem_rsp_valid) begin
            state_q       <= RESPOND;
            cpu_rsp_rdata <= lat_we_q ? lat_wdata_q : mem_rsp_rdata;
          end
        end
        RESPOND: begin
          cpu_rsp_valid <= 1'b1;
          state_q       <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Saturating statistics, counted at request acceptance
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (accept) begin
      if (hit) begin
        if (hit_count != '1) hit_count <= hit_count + CNT_WIDTH'(1);
      end else begin
        if (miss_count != '1) miss_count <= miss_count + CNT_WIDTH'(1);
      end
    end
  end
endmodule

// File: tb/tb_nway_wb_cache.sv
// Bench for nway_wb_cache: flat-memory reference with a timestamp-LRU cache
// model, a single negedge compare/memory-responder process, directed vectors.
module tb_nway_wb_cache;
  localparam int DW = 32, AW = 32, WAYS = 4, SETS = 8, CW = 4;
  localparam int CMAX = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, cpu_req_valid, cpu_req_ready, cpu_req_we, cpu_rsp_valid;
  logic [AW-1:0] cpu_req_addr, mem_req_addr;
  logic [DW-1:0] cpu_req_wdata, cpu_rsp_rdata, mem_req_wdata, mem_rsp_rdata;
  logic          mem_req_valid, mem_req_ready, mem_req_we, mem_rsp_valid;
  logic [CW-1:0] hit_count, miss_count;

  nway_wb_cache #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WAYS(WAYS), .SETS(SETS), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready), .cpu_req_we(cpu_req_we),
    .cpu_req_addr(cpu_req_addr), .cpu_req_wdata(cpu_req_wdata),
    .cpu_rsp_valid(cpu_rsp_valid), .cpu_rsp_rdata(cpu_rsp_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  int tests = 0, fails = 0;

  typedef struct packed { logic we; logic [31:0] addr; logic [31:0] data; } mreq_t;
  mreq_t       exp_mem[$];
  mreq_t       mem_log[$];
  logic [31:0] exp_rsp[$];
  logic [31:0] ref_flat  [logic [31:0]];  // what a load must return
  logic [31:0] m_mem     [logic [31:0]];  // what memory must hold
  logic [31:0] mem_store [logic [31:0]];  // bench memory contents
  bit          m_valid [SETS][WAYS];
  bit          m_dirty [SETS][WAYS];
  logic [26:0] m_tag   [SETS][WAYS];
  int          m_stamp [SETS][WAYS];
  int          stamp_ctr = 0, m_hits = 0, m_misses = 0;
  int          stall_left = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return 32'hAAAA0000 ^ a;
  endfunction

  function automatic logic [31:0] ref_val(input logic [31:0] a);
    return ref_flat.exists(a) ? ref_flat[a] : init_val(a);
  endfunction

  function automatic void model_accept(input logic we, input logic [31:0] addr, input logic [31:0] wd);
    logic [31:0] a, va;
    logic [26:0] t;
    int s, v;
    mreq_t r;
    a = {addr[31:2], 2'b00};
    s = int'(a[4:2]);
    t = a[31:5];
    v = -1;
    stamp_ctr++;
    for (int w = 0; w < WAYS; w++) if (m_valid[s][w] && m_tag[s][w] == t) v = w;
    if (v >= 0) begin
      if (m_hits < CMAX) m_hits++;
      if (we) begin m_dirty[s][v] = 1; ref_flat[a] = wd; end
    end else begin
      if (m_misses < CMAX) m_misses++;
      for (int w = WAYS - 1; w >= 0; w--) if (!m_valid[s][w]) v = w;
      if (v < 0) begin
        v = 0;
        for (int w = 1; w < WAYS; w++) if (m_stamp[s][w] < m_stamp[s][v]) v = w;
        if (m_dirty[s][v]) begin
          va = {m_tag[s][v], a[4:2], 2'b00};
          r.we = 1'b1; r.addr = va; r.data = ref_val(va);
          exp_mem.push_back(r);
          m_mem[va] = r.data;
        end
      end
      r.we = 1'b0; r.addr = a; r.data = '0;
      exp_mem.push_back(r);
      m_valid[s][v] = 1; m_tag[s][v] = t; m_dirty[s][v] = we;
      if (we) ref_flat[a] = wd;
    end
    m_stamp[s][v] = stamp_ctr;
    exp_rsp.push_back(we ? wd : ref_val(a));
  endfunction

  function automatic void model_reset();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) begin m_valid[s][w] = 0; m_dirty[s][w] = 0; end
    m_hits = 0; m_misses = 0;
    exp_rsp.delete(); exp_mem.delete();
    ref_flat = m_mem;
  endfunction

  // Compare process and memory responder, all on the falling edge
  initial begin
    int pend;
    logic [31:0] pend_data;
    bit snap_ok;
    mreq_t snap, cur, e;
    pend = 0; pend_data = '0; snap_ok = 0; snap = '0;
    forever begin
      @(negedge clk);
      mem_rsp_valid = 1'b0;
      if (rst) begin
        pend = 0; snap_ok = 0; mem_req_ready = 1'b0;
      end else begin
        check("hit_count", 32'(hit_count), 32'(m_hits));
        check("miss_count", 32'(miss_count), 32'(m_misses));
        if (cpu_rsp_valid) begin
          if (exp_rsp.size() == 0) check("unexpected_rsp", 32'(cpu_rsp_valid), 32'd0);
          else check("rsp_rdata", cpu_rsp_rdata, exp_rsp.pop_front());
        end
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin mem_rsp_valid = 1'b1; mem_rsp_rdata = pend_data; end
        end
        mem_req_ready = 1'b0;
        if (mem_req_valid) begin
          cur.we = mem_req_we; cur.addr = mem_req_addr; cur.data = mem_req_wdata;
          if (snap_ok) begin
            check("stall_we", 32'(cur.we), 32'(snap.we));
            check("stall_addr", cur.addr, snap.addr);
            check("stall_wdata", cur.data, snap.data);
          end
          if (stall_left > 0) begin
            check("stall_cpu_ready", 32'(cpu_req_ready), 32'd0);
            snap = cur; snap_ok = 1; stall_left--;
          end else begin
            snap_ok = 0;
            mem_req_ready = 1'b1;
            mem_log.push_back(cur);
            if (exp_mem.size() == 0) check("unexpected_mem_req", cur.addr, 32'hFFFFFFFF);
            else begin
              e = exp_mem.pop_front();
              check("mem_we", 32'(cur.we), 32'(e.we));
              check("mem_addr", cur.addr, e.addr);
              if (e.we) check("mem_wdata", cur.data, e.data);
            end
            if (cur.we) mem_store[cur.addr] = cur.data;
            else begin
              pend = 3;
              pend_data = mem_store.exists(cur.addr) ? mem_store[cur.addr] : init_val(cur.addr);
            end
          end
        end
      end
    end
  end

  // One CPU request; caller is at a falling edge, returns at the response edge
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       output int lat, output logic [31:0] rd);
    int n = 0;
    lat = -1; rd = '0;
    while (!cpu_req_ready && n < 200) begin @(negedge clk); n++; end
    if (!cpu_req_ready) begin
      check("ready_timeout", 32'(cpu_req_ready), 32'd1);
      return;
    end
    cpu_req_valid = 1'b1; cpu_req_we = we; cpu_req_addr = addr; cpu_req_wdata = wd;
    @(posedge clk);
    model_accept(we, addr, wd);
    @(negedge clk);
    cpu_req_valid = 1'b0;
    lat = 1;
    while (!cpu_rsp_valid && lat < 200) begin @(negedge clk); lat++; end
    if (!cpu_rsp_valid) check("rsp_timeout", 32'(cpu_rsp_valid), 32'd1);
    rd = cpu_rsp_rdata;
    $display("[TB] %s addr=%h wdata=%h rdata=%h latency=%0d", we ? "ST" : "LD", addr, wd, rd, lat);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, lat2, n0, n;
    logic [31:0] rd, rd2;
    rst = 1'b1; cpu_req_valid = 1'b0; cpu_req_we = 1'b0; cpu_req_addr = '0; cpu_req_wdata = '0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_rdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_ready", 32'(cpu_req_ready), 32'd1);
    check("rst_rsp_valid", 32'(cpu_rsp_valid), 32'd0);
    check("rst_rsp_rdata", cpu_rsp_rdata, 32'd0);
    check("rst_mem_valid", 32'(mem_req_valid), 32'd0);
    check("rst_mem_we", 32'(mem_req_we), 32'd0);
    check("rst_mem_addr", mem_req_addr, 32'd0);
    check("rst_mem_wdata", mem_req_wdata, 32'd0);
    check("rst_counters", 32'({hit_count, miss_count}), 32'd0);

    // Cold miss then hit
    n0 = mem_log.size();
    issue(1'b0, 32'h000, 32'h0, lat, rd);
    check("cold_rdata", rd, 32'hAAAA0000);
    check("cold_mem_reqs", 32'(mem_log.size() - n0), 32'd1);
    check("cold_req_we", 32'(mem_log[n0].we), 32'd0);
    check("cold_req_addr", mem_log[n0].addr, 32'h000);
    issue(1'b0, 32'h000, 32'h0, lat, rd);
    check("repeat_hit_latency", 32'(lat), 32'd1);
    check("repeat_rdata", rd, 32'hAAAA0000);
    check("repeat_hits", 32'(hit_count), 32'd1);
    check("repeat_misses", 32'(miss_count), 32'd1);

    // LRU eviction in set 0
    issue(1'b0, 32'h020, 32'h0, lat, rd);
    issue(1'b0, 32'h040, 32'h0, lat, rd);
    issue(1'b0, 32'h060, 32'h0, lat, rd);
    issue(1'b0, 32'h080, 32'h0, lat, rd);
    issue(1'b0, 32'h000, 32'h0, lat, rd);
    check("reload_000_is_miss", 32'(lat > 1), 32'd1);
    issue(1'b0, 32'h040, 32'h0, lat, rd);
    check("load_040_is_hit", 32'(lat), 32'd1);
    issue(1'b0, 32'h020, 32'h0, lat, rd);
    check("load_020_is_miss", 32'(lat > 1), 32'd1);
    check("load_020_rdata", rd, 32'hAAAA0020);

    // Dirty allocate, eviction with write-back under a stalled memory
    issue(1'b1, 32'h100, 32'h12345678, lat, rd);
    check("store_echo", rd, 32'h12345678);
    issue(1'b0, 32'h180, 32'h0, lat, rd);
    issue(1'b0, 32'h1A0, 32'h0, lat, rd);
    issue(1'b0, 32'h1C0, 32'h0, lat, rd);
    n0 = mem_log.size();
    stall_left = 5;
    issue(1'b0, 32'h1E0, 32'h0, lat, rd);
    check("wb_mem_reqs", 32'(mem_log.size() - n0), 32'd2);
    check("wb_first_we", 32'(mem_log[n0].we), 32'd1);
    check("wb_first_addr", mem_log[n0].addr, 32'h100);
    check("wb_first_wdata", mem_log[n0].data, 32'h12345678);
    check("wb_then_refill_addr", mem_log[n0+1].addr, 32'h1E0);
    check("wb_refill_rdata", rd, 32'hAAAA01E0);
    check("stall_consumed", 32'(stall_left), 32'd0);
    issue(1'b0, 32'h100, 32'h0, lat, rd);
    check("reload_written_back", rd, 32'h12345678);

    // Back-to-back store then load hit
    issue(1'b0, 32'h040, 32'h0, lat, rd);
    n0 = mem_log.size();
    issue(1'b1, 32'h040, 32'h5, lat, rd);
    issue(1'b0, 32'h040, 32'h0, lat2, rd2);
    check("b2b_store_latency", 32'(lat), 32'd1);
    check("b2b_load_latency", 32'(lat2), 32'd1);
    check("b2b_load_rdata", rd2, 32'h5);
    check("b2b_no_mem", 32'(mem_log.size() - n0), 32'd0);

    // Miss counter saturation
    for (int i = 0; i < 8; i++) issue(1'b0, 32'h400 + 32'(4 * i), 32'h0, lat, rd);
    check("miss_saturated", 32'(miss_count), 32'hF);

    // Reset while waiting for refill data
    n0 = mem_log.size();
    cpu_req_valid = 1'b1; cpu_req_we = 1'b0; cpu_req_addr = 32'h200;
    @(posedge clk);
    model_accept(1'b0, 32'h200, 32'h0);
    @(negedge clk);
    cpu_req_valid = 1'b0;
    n = 0;
    while (!(mem_log.size() > n0 && mem_log[mem_log.size()-1].we == 1'b0 &&
             mem_log[mem_log.size()-1].addr == 32'h200) && n < 200) begin
      @(negedge clk); n++;
    end
    check("refill_200_issued", 32'(n < 200), 32'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    model_reset();
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_mem_valid", 32'(mem_req_valid), 32'd0);
    check("midrst_rsp_valid", 32'(cpu_rsp_valid), 32'd0);
    check("midrst_idle", 32'(cpu_req_ready), 32'd1);
    check("midrst_counters", 32'({hit_count, miss_count}), 32'd0);
    issue(1'b0, 32'h000, 32'h0, lat, rd);
    check("post_rst_miss", 32'(lat > 1), 32'd1);
    check("post_rst_rdata", rd, 32'hAAAA0000);
    check("post_rst_misses", 32'(miss_count), 32'd1);
    issue(1'b0, 32'h040, 32'h0, lat, rd);
    check("dirty_discarded", rd, 32'hAAAA0040);
    repeat (3) @(negedge clk);
    check("rsp_queue_drained", 32'(exp_rsp.size()), 32'd0);
    check("mem_queue_drained", 32'(exp_mem.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/nway_wb_cache.md
Name: nway_wb_cache

Overview:
- Parametrised N-way set-associative data cache with write-back, write-allocate and true-LRU replacement.
- One DATA_WIDTH word per line.
- Sits between the CPU load/store stage and data memory, using valid/ready handshakes on both sides.
- Provides hit/miss statistics counters for performance analysis.

Parameters:
DATA_WIDTH, 32, word and line width in bits
ADDR_WIDTH, 32, byte address width
WAYS, 4, associativity; power of 2, >=2
SETS, 8, number of sets; power of 2, >=2
CNT_WIDTH, 32, width of statistics counters
Derived (localparam): SET_WIDTH=clog2(SETS), TAG_WIDTH=ADDR_WIDTH-SET_WIDTH-2, AGE_WIDTH=clog2(WAYS)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
cpu_req_valid  in  1  CPU request valid
cpu_req_ready  out  1  cache can accept request
cpu_req_we  in  1  1=store, 0=load
cpu_req_addr  in  ADDR_WIDTH  byte address; bits [1:0] ignored
cpu_req_wdata  in  DATA_WIDTH  store data (full word)
cpu_rsp_valid  out  1  one-cycle response pulse
cpu_rsp_rdata  out  DATA_WIDTH  load data; store data echoed on stores
mem_req_valid  out  1  memory request valid
mem_req_ready  in  1  memory accepts request
mem_req_we  out  1  1=write-back, 0=refill read
mem_req_addr  out  ADDR_WIDTH  word-aligned address ([1:0]=0)
mem_req_wdata  out  DATA_WIDTH  victim data on write-back
mem_rsp_valid  in  1  refill data valid
mem_rsp_rdata  in  DATA_WIDTH  refill data
hit_count  out  CNT_WIDTH  accepted requests that hit; saturating
miss_count  out  CNT_WIDTH  accepted requests that missed; saturating

Behaviour:
- Address split: set = addr[SET_WIDTH+1:2]; tag = addr[ADDR_WIDTH-1:SET_WIDTH+2].
- Per line state: valid, dirty, tag, data, age (AGE_WIDTH).
- Reset values:
  - All valid=0, dirty=0.
  - age[s][w]=w for every set s.
  - FSM=IDLE.
  - cpu_rsp_valid=0, cpu_rsp_rdata=0.
  - mem_req_valid=0, mem_req_we=0, mem_req_addr=0, mem_req_wdata=0.
  - Both counters=0.
- Reset mid-operation:
  - Any outstanding memory transaction is abandoned and dirty data is discarded.
  - mem_req_valid is low in the cycle after rst.
- FSM states: IDLE, WRITEBACK, REFILL_REQ, REFILL_WAIT, RESPOND.
- cpu_req_ready = (state==IDLE) && !rst.
- Accept = cpu_req_valid && cpu_req_ready. Tag compare is combinational on cpu_req_addr in IDLE.
- Hit (accepted in cycle T):
  - Load: rdata = line data.
  - Store: line data=wdata, dirty=1, rdata=wdata.
  - cpu_rsp_valid=1 in T+1; state stays IDLE.
  - Back-to-back hits every cycle are allowed. A request in T+1 sees T's update.
- Miss (accepted in T):
  - Request is latched.
  - Victim = lowest-index invalid way; else the way with age==WAYS-1.
  - If the victim is valid and dirty: go to WRITEBACK. Otherwise go to REFILL_REQ.
- WRITEBACK:
  - mem_req_valid=1, we=1, addr={victim tag,set,2'b00}, wdata=victim data.
  - Signals are held stable until mem_req_ready.
  - Then go to REFILL_REQ.
- REFILL_REQ:
  - mem_req_valid=1, we=0, addr={req tag,set,2'b00}, held until mem_req_ready.
  - Then go to REFILL_WAIT with mem_req_valid=0.
- REFILL_WAIT:
  - On mem_rsp_valid (cycle M), install the line: valid=1, tag=req tag.
  - Load: data=mem_rsp_rdata, dirty=0.
  - Store: data=wdata, dirty=1.
  - Then go to RESPOND.
- RESPOND:
  - cpu_rsp_valid=1 with load data or echoed store data.
  - Return to IDLE; ready is high again in the same cycle.
- mem_rsp_valid outside REFILL_WAIT is ignored.
- LRU update on every hit and on every install into way w with old age a:
  - Ways in the set with age<a increment.
  - age[w]=0.
  - Ages in each set always remain a permutation of 0..WAYS-1.
- Counters increment on accept; they saturate at all-ones and never wrap.
- cpu_rsp_valid is never high for more than one cycle per accepted request. Responses are returned in order.

Test Plan:
- Cold load 0x000 with mem_rsp_rdata=0xAAAA0000 -> REFILL_REQ addr 0x000 we=0, no write-back, cpu_rsp_rdata=0xAAAA0000; repeat load 0x000 -> rsp next cycle, hit_count=1, miss_count=1.
- WAYS=4, SETS=8: load 0x000,0x020,0x040,0x060 (set 0), then 0x080 -> 0x000 evicted; reload 0x000 -> miss, 0x020 evicted.
- Store 0x100 data 0x12345678 (miss, allocate dirty), then fill set 0 with 4 other tags -> mem write-back addr 0x100 wdata 0x12345678 precedes refill read.
- Stall mem_req_ready low 5 cycles during WRITEBACK -> mem_req_addr/wdata/we stable, cpu_req_ready=0 throughout.
- Back-to-back hits: store 0x040=0x5 in T, load 0x040 in T+1 -> rsp rdata=0x5 in T+2, no memory traffic.
- Assert rst in REFILL_WAIT -> next cycle mem_req_valid=0, state IDLE, load 0x000 misses, counters=0.
